pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the PC loaded by reset.
REQ-003 The block SHALL have parameter INC, default 4, giving the sequential fetch increment.
REQ-004 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, giving the misalignment trap target.
REQ-005 The block SHALL have port CLK, input, 1 bit, the single clock; all state SHALL update on the falling edge.
REQ-006 The block SHALL have port RESET, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port StallF, input, 1 bit, which holds the fetch PC.
REQ-008 The block SHALL have port RedirectE, input, 1 bit, which signals a taken branch or jump from EX.
REQ-009 The block SHALL have port TargetE, input, XLEN bits, the redirect target.
REQ-010 The block SHALL have port HaltReq, input, 1 bit, which requests that fetch stop.
REQ-011 The block SHALL have port PCF, output, XLEN bits, the current fetch PC.
REQ-012 The block SHALL have port PCPlusF, output, XLEN bits, equal to PCF+INC combinationally.
REQ-013 The block SHALL have port ValidF, output, 1 bit, which marks PCF as a real fetch.
REQ-014 The block SHALL have port RedirPending, output, 1 bit, which shows that a buffered redirect is awaiting stall release.
REQ-015 The block SHALL have port MisalignF, output, 1 bit, a one-cycle misalignment trap flag.

Function
REQ-016 The block SHALL implement the states BOOT, RUN and HALTED.
REQ-017 After reset the block SHALL be in BOOT for exactly one edge, with PCF=RESET_VECTOR and ValidF=0, and SHALL then go to RUN with PCF unchanged.
REQ-018 In RUN, the next-PC priority SHALL be RESET > RedirectE > pending buffer > StallF > PCF+INC.
REQ-019 In RUN with StallF=0 and RedirectE=1, PCF SHALL equal TargetE after the next edge.
REQ-020 In RUN with StallF=1 and RedirectE=1, PCF SHALL be held, TargetE SHALL be latched into the buffer, and RedirPending SHALL be 1 from the next edge.
REQ-021 A further redirect while the buffer is pending SHALL overwrite the buffer, so the newest target wins.
REQ-022 At the first edge with StallF=0 and RedirectE=0 while pending, PCF SHALL load the buffered target and RedirPending SHALL clear at the same edge.
REQ-023 When StallF=0, RedirectE=1 and a redirect is pending, TargetE SHALL be used and the buffer SHALL be cleared.
REQ-024 The increment SHALL wrap modulo 2^XLEN; for XLEN=32 and INC=4, PCF=32'hFFFF_FFFC SHALL be followed by 32'h0000_0000.
REQ-025 HaltReq=1 in RUN without a redirect SHALL move the block to HALTED at the next edge, with PCF held and ValidF=0.
REQ-026 When HaltReq and RedirectE are both asserted in the same cycle, the redirect SHALL win and the block SHALL stay in RUN.
REQ-027 HALTED SHALL be left only on RedirectE, which moves the block to RUN with PCF=TargetE regardless of StallF, or on RESET.
REQ-028 ValidF SHALL be 1 in RUN only, including while stalled.
REQ-029 StallF=X SHALL be treated as 0.

Reset
REQ-030 RESET=1 sampled at an edge SHALL set PCF=RESET_VECTOR, state=BOOT, RedirPending=0, buffer=0, MisalignF=0 and ValidF=0.
REQ-031 Reset SHALL override every other input, including in the middle of a stall, a pending redirect or a halt.

Configuration
REQ-032 With macro PC_MISALIGN_TRAP_EN defined, any applied redirect target with TargetE[1:0]!=0 SHALL load PCF=TRAP_VECTOR and pulse MisalignF=1 for one cycle.
REQ-033 A buffered redirect SHALL be checked for misalignment when it is applied, not when it is latched.
REQ-034 Without PC_MISALIGN_TRAP_EN, targets SHALL be used unmodified and MisalignF SHALL be tied to 0.

Structure
REQ-035 Package pc_pkg SHALL hold the state enum pc_state_t (BOOT, RUN, HALTED) and the default vector constants.
REQ-036 The single-entry target buffer and its pending flag SHALL be the sub-module pc_redirect_buf, with ports CLK, RESET, load, clear, target_in, target_out and pending.

Verification
REQ-037 The bench SHALL cover reset then free-run: RESET 1->0 gives PCF 0, 0 (BOOT, ValidF=0), 4, 8, 12 with ValidF=1.
REQ-038 The bench SHALL cover a stall: StallF=1 for 3 edges at PCF=8 holds PCF at 8, and after release PCF=12.
REQ-039 The bench SHALL cover a redirect under stall: with StallF=1, RedirectE=1 and TargetE=0x40, then 0x80 one edge later, RedirPending=1 and PCF is held; on release PCF=0x80 and RedirPending=0.
REQ-040 The bench SHALL cover halt and restart: HaltReq gives HALTED with ValidF=0 and PCF held; RedirectE with TargetE=0x200 gives PCF=0x200 in RUN.
REQ-041 The bench SHALL cover wrap: PCF=0xFFFF_FFFC followed by PCF=0x0000_0000.
REQ-042 With PC_MISALIGN_TRAP_EN, the bench SHALL drive TargetE=0x42 and check PCF=0x100 with MisalignF high for exactly one cycle; without the macro, it SHALL check PCF=0x42 and MisalignF=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch PC unit.
package pc_pkg;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  // Default geometry and vectors.
  localparam int          PC_DEF_XLEN         = 32;
  localparam int unsigned PC_DEF_INC          = 4;
  localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage : pc_pkg

// File: rtl/pc_redirect_buf.sv
// Single-entry redirect target buffer with a pending flag.
// Holds a branch/jump target that arrived while fetch was stalled.
// A load always overwrites the entry so the newest target wins.
module pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] target_in,
  output logic [XLEN-1:0] target_out,
  output logic            pending
);

  logic [XLEN-1:0] r_target;
  logic            r_pending;

  // Capture on load, drop on clear; load wins if both are raised.
  always_ff @(negedge CLK) begin
    if (RESET) begin
      r_target  <= '0;
      r_pending <= 1'b0;
    end else if (load) begin
      r_target  <= target_in;
      r_pending <= 1'b1;
    end else if (clear) begin
      r_target  <= '0;
      r_pending <= 1'b0;
    end
  end

  assign target_out = r_target;
  assign pending    = r_pending;

endmodule : pc_redirect_buf

// File: rtl/pc_unit.sv
// Fetch program counter unit: BOOT/RUN/HALTED sequencing, sequential
// increment, EX redirects (buffered while stalled) and halt.
// All state updates on the falling edge of CLK; RESET is synchronous.
// Optional feature macro PC_MISALIGN_TRAP_EN: applied redirect targets with
// nonzero low two bits are replaced by TRAP_VECTOR and MisalignF pulses.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_DEF_RESET_VECTOR),
  parameter int unsigned     INC          = PC_DEF_INC,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_DEF_TRAP_VECTOR)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            StallF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            HaltReq,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlusF,
  output logic            ValidF,
  output logic            RedirPending,
  output logic            MisalignF
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  pc_state_t       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_misalign, w_misalign_nxt;
  logic            w_stall;
  logic            w_buf_load, w_buf_clear, w_pending;
  logic [XLEN-1:0] w_buf_target;
  logic [XLEN-1:0] w_sel_target;
  logic            w_apply;
  logic [XLEN-1:0] w_pc_inc;

  // An unknown stall is treated as no stall so fetch keeps moving.
  assign w_stall  = (StallF === 1'b1);
  assign w_pc_inc = r_pc + XLEN'(INC);

  pc_redirect_buf #(.XLEN(XLEN)) u_rbuf (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (w_buf_load),
    .clear      (w_buf_clear),
    .target_in  (TargetE),
    .target_out (w_buf_target),
    .pending    (w_pending)
  );

  // State register.
  always_ff @(negedge CLK) begin
    if (RESET) r_state <= BOOT;
    else       r_state <= w_state_nxt;
  end

  // Next state: BOOT lasts one edge; halt only when no redirect competes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     if (!RedirectE && HaltReq) w_state_nxt = HALTED;
      HALTED:  if (RedirectE) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Next PC and buffer control: redirect > pending buffer > stall > increment.
  // A redirect under stall is parked in the buffer; it is applied (and
  // alignment-checked) only when the stall releases.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_sel_target   = TargetE;
    w_apply        = 1'b0;
    w_buf_load     = 1'b0;
    w_buf_clear    = 1'b0;
    w_misalign_nxt = 1'b0;
    case (r_state)
      RUN: begin
        if (RedirectE) begin
          if (w_stall) begin
            w_buf_load = 1'b1;
          end else begin
            w_apply     = 1'b1;
            w_buf_clear = 1'b1;
          end
        end else if (HaltReq) begin
          w_pc_nxt = r_pc;
        end else if (w_pending && !w_stall) begin
          w_apply      = 1'b1;
          w_sel_target = w_buf_target;
          w_buf_clear  = 1'b1;
        end else if (!w_stall) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      HALTED: begin
        if (RedirectE) begin
          w_apply     = 1'b1;
          w_buf_clear = 1'b1;
        end
      end
      default: w_pc_nxt = r_pc;
    endcase
    if (w_apply) begin
      w_pc_nxt = w_sel_target;
      if (TRAP_EN && (w_sel_target[1:0] != 2'b00)) begin
        w_pc_nxt       = TRAP_VECTOR;
        w_misalign_nxt = 1'b1;
      end
    end
  end

  // PC and misalignment flag registers; the flag lives for one cycle.
  always_ff @(negedge CLK) begin
    if (RESET) begin
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // Outputs: fetch is real only in RUN (stalled or not).
  always_comb begin
    ValidF       = (r_state == RUN);
    PCF          = r_pc;
    PCPlusF      = w_pc_inc;
    RedirPending = w_pending;
    MisalignF    = TRAP_EN ? r_misalign : 1'b0;
  end

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit (default parameters).
// Inputs change 1ns after each falling edge; outputs are checked there too.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RESET, StallF, RedirectE, HaltReq;
  logic [31:0] TargetE;
  logic [31:0] PCF, PCPlusF;
  logic        ValidF, RedirPending, MisalignF;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        vld;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  pc_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .StallF       (StallF),
    .RedirectE    (RedirectE),
    .TargetE      (TargetE),
    .HaltReq      (HaltReq),
    .PCF          (PCF),
    .PCPlusF      (PCPlusF),
    .ValidF       (ValidF),
    .RedirPending (RedirPending),
    .MisalignF    (MisalignF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Expected PC after applying a redirect target.
  function automatic logic [31:0] tgt_pc(input logic [31:0] t);
    logic [1:0] lo;
    lo = t[1:0];
    return (TRAP && lo != 2'b00) ? 32'h0000_0100 : t;
  endfunction

  function automatic logic tgt_mis(input logic [31:0] t);
    logic [1:0] lo;
    lo = t[1:0];
    return TRAP && (lo != 2'b00);
  endfunction

  // Wait one active edge, pop the expectation and compare every output.
  task automatic edge_chk();
    exp_t e;
    @(negedge CLK);
    #1;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty: got %0d entries, need 1", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (PCF === e.pc) else begin
        n_fail++;
        $error("FAIL %s.PCF got %h exp %h", e.tag, PCF, e.pc);
      end
      n_cmp++;
      assert (PCPlusF === e.pc + 32'd4) else begin
        n_fail++;
        $error("FAIL %s.PCPlusF got %h exp %h", e.tag, PCPlusF, e.pc + 32'd4);
      end
      n_cmp++;
      assert (ValidF === e.vld) else begin
        n_fail++;
        $error("FAIL %s.ValidF got %b exp %b", e.tag, ValidF, e.vld);
      end
      n_cmp++;
      assert (RedirPending === e.pend) else begin
        n_fail++;
        $error("FAIL %s.RedirPending got %b exp %b", e.tag, RedirPending, e.pend);
      end
      n_cmp++;
      assert (MisalignF === e.mis) else begin
        n_fail++;
        $error("FAIL %s.MisalignF got %b exp %b", e.tag, MisalignF, e.mis);
      end
    end
  endtask

  // Drive one cycle of inputs, record its expected outcome, then check it.
  task automatic step(input string tag, input logic rst, input logic stl,
                      input logic rd, input logic [31:0] tgt, input logic hlt,
                      input logic [31:0] pc, input logic vld,
                      input logic pend, input logic mis);
    exp_t e;
    RESET = rst; StallF = stl; RedirectE = rd; TargetE = tgt; HaltReq = hlt;
    e.tag = tag; e.pc = pc; e.vld = vld; e.pend = pend; e.mis = mis;
    sb.push_back(e);
    edge_chk();
  endtask

  initial begin
    RESET = 1'b1; StallF = 1'b0; RedirectE = 1'b0; TargetE = '0; HaltReq = 1'b0;
    @(posedge CLK);
    //    tag        rst stl rd  target         hlt pc             vld pend mis
    // reset then free run
    step("reset",    1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0);
    step("boot",     0, 0, 0, 32'h0,          0, 32'h0,          1, 0, 0);
    step("run4",     0, 0, 0, 32'h0,          0, 32'h4,          1, 0, 0);
    step("run8",     0, 0, 0, 32'h0,          0, 32'h8,          1, 0, 0);
    // stall for three edges at 8
    step("stall1",   0, 1, 0, 32'h0,          0, 32'h8,          1, 0, 0);
    step("stall2",   0, 1, 0, 32'h0,          0, 32'h8,          1, 0, 0);
    step("stall3",   0, 1, 0, 32'h0,          0, 32'h8,          1, 0, 0);
    step("release",  0, 0, 0, 32'h0,          0, 32'hC,          1, 0, 0);
    step("run10",    0, 0, 0, 32'h0,          0, 32'h10,         1, 0, 0);
    // redirect under stall, newest target wins
    step("rbuf40",   0, 1, 1, 32'h40,         0, 32'h10,         1, 1, 0);
    step("rbuf80",   0, 1, 1, 32'h80,         0, 32'h10,         1, 1, 0);
    step("rbufhold", 0, 1, 0, 32'h0,          0, 32'h10,         1, 1, 0);
    step("rbufrel",  0, 0, 0, 32'h0,          0, 32'h80,         1, 0, 0);
    step("run84",    0, 0, 0, 32'h0,          0, 32'h84,         1, 0, 0);
    // live redirect beats a pending one
    step("pend300",  0, 1, 1, 32'h300,        0, 32'h84,         1, 1, 0);
    step("live400",  0, 0, 1, 32'h400,        0, 32'h400,        1, 0, 0);
    step("run404",   0, 0, 0, 32'h0,          0, 32'h404,        1, 0, 0);
    // unknown stall behaves as no stall
    step("stallx",   0, 1'bx, 0, 32'h0,       0, 32'h408,        1, 0, 0);
    // halt then restart
    step("halt",     0, 0, 0, 32'h0,          1, 32'h408,        0, 0, 0);
    step("halted",   0, 0, 0, 32'h0,          0, 32'h408,        0, 0, 0);
    step("haltstl",  0, 1, 0, 32'h0,          0, 32'h408,        0, 0, 0);
    step("restart",  0, 1, 1, 32'h200,        0, 32'h200,        1, 0, 0);
    step("run204",   0, 0, 0, 32'h0,          0, 32'h204,        1, 0, 0);
    // halt and redirect together: redirect wins
    step("hltredir", 0, 0, 1, 32'h500,        1, 32'h500,        1, 0, 0);
    step("run504",   0, 0, 0, 32'h0,          0, 32'h504,        1, 0, 0);
    // wrap
    step("tofffc",   0, 0, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,  1, 0, 0);
    step("wrap0",    0, 0, 0, 32'h0,          0, 32'h0,          1, 0, 0);
    step("wrap4",    0, 0, 0, 32'h0,          0, 32'h4,          1, 0, 0);
    // misaligned live redirect
    step("mis42",    0, 0, 1, 32'h42,         0, tgt_pc(32'h42), 1, 0, tgt_mis(32'h42));
    step("misnext",  0, 0, 0, 32'h0,          0, tgt_pc(32'h42) + 32'd4, 1, 0, 0);
    // misaligned buffered redirect: checked on apply
    step("mbufld",   0, 1, 1, 32'h42,         0, tgt_pc(32'h42) + 32'd4, 1, 1, 0);
    step("mbufapp",  0, 0, 0, 32'h0,          0, tgt_pc(32'h42), 1, 0, tgt_mis(32'h42));
    step("mbufnext", 0, 0, 0, 32'h0,          0, tgt_pc(32'h42) + 32'd4, 1, 0, 0);
    // reset overrides a pending stall/redirect
    step("pend40",   0, 1, 1, 32'h40,         0, tgt_pc(32'h42) + 32'd4, 1, 1, 0);
    step("rstmid",   1, 1, 1, 32'h40,         1, 32'h0,          0, 0, 0);
    step("reboot",   0, 0, 0, 32'h0,          0, 32'h0,          1, 0, 0);
    step("rerun",    0, 0, 0, 32'h0,          0, 32'h4,          1, 0, 0);
    // reset overrides halt
    step("halt2",    0, 0, 0, 32'h0,          1, 32'h4,          0, 0, 0);
    step("rsthalt",  1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0);
    step("boot2",    0, 0, 0, 32'h0,          0, 32'h0,          1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pc_unit
